// File: rtl/apb_pkg.sv
// Shared definitions for the two-port APB master: FSM state encodings,
// byte width used to derive strobe width, and a one-hot helper.
package apb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'b00;
  localparam state_t ST_SETUP  = 2'b01;
  localparam state_t ST_ACCESS = 2'b10;

  localparam int BYTE_W = 8;

  // Expand a requester index into its one-hot grant/done vector.
  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational pick between two requesters,
// with a registered "served last" pointer that moves only when a transfer
// completes, so a pending grant never rotates priority by itself.
module rr_arbiter_2
  import apb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  input  logic       upd_id_i,
  output logic       pick_vld_o,
  output logic       pick_id_o
);

  // last_q = index of the requester served most recently; reset value 1
  // makes requester 0 the favoured one after reset.
  logic last_q;
  logic last_d;

  // Pick the requester not served last on a tie, otherwise the lone requester.
  always_comb begin
    pick_vld_o = |req_i;
    if (req_i == 2'b11) begin
      pick_id_o = ~last_q;
    end else begin
      pick_id_o = req_i[1];
    end
    last_d = upd_i ? upd_id_i : last_q;
  end

  // Pointer register, advanced on completion only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master. Arbitrates round-robin, runs SETUP/ACCESS toward
// a single APB slave, and returns read data / error to the winner. A watchdog
// force-completes an ACCESS phase the slave never acknowledges.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int BUS_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_DIM    = BUS_WIDTH / BYTE_W,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_i,
  input  logic [1:0]            wr_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [BUS_WIDTH-1:0]  wdata0_i,
  input  logic [BUS_WIDTH-1:0]  wdata1_i,
  input  logic [MAX_DIM-1:0]    strb0_i,
  input  logic [MAX_DIM-1:0]    strb1_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            done_o,
  output logic [BUS_WIDTH-1:0]  rdata_o,
  output logic                  err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [BUS_WIDTH-1:0]  pwdata_o,
  output logic [MAX_DIM-1:0]    pstrb_o,
  input  logic [BUS_WIDTH-1:0]  prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                  state_q,   state_d;
  logic                    owner_q,   owner_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic                    psel_q,    psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q,  pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
  logic [BUS_WIDTH-1:0]    pwdata_q,  pwdata_d;
  logic [MAX_DIM-1:0]      pstrb_q,   pstrb_d;
  logic [1:0]              gnt_q,     gnt_d;
  logic [1:0]              done_q,    done_d;
  logic [BUS_WIDTH-1:0]    rdata_q,   rdata_d;
  logic                    err_q,     err_d;

  logic                    pick_vld;
  logic                    pick_id;
  logic                    xfer_end;

  rr_arbiter_2 u_arb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .upd_i      (xfer_end),
    .upd_id_i   (owner_q),
    .pick_vld_o (pick_vld),
    .pick_id_o  (pick_id)
  );

  // Next-state logic: grant/latch in IDLE, SETUP->ACCESS, complete on
  // pready or watchdog expiry. APB controls are registered from here.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    gnt_d     = 2'b00;
    done_d    = 2'b00;
    xfer_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          owner_d   = pick_id;
          pwrite_d  = wr_i[pick_id];
          if (pick_id) begin
            paddr_d  = addr1_i;
            pwdata_d = wdata1_i;
            pstrb_d  = wr_i[1] ? strb1_i : '0;
          end else begin
            paddr_d  = addr0_i;
            pwdata_d = wdata0_i;
            pstrb_d  = wr_i[0] ? strb0_i : '0;
          end
          gnt_d     = onehot2(pick_id);
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (pready_i) begin
          rdata_d   = pwrite_q ? '0 : prdata_i;
          err_d     = pslverr_i;
          done_d    = onehot2(owner_q);
          psel_d    = 1'b0;
          penable_d = 1'b0;
          xfer_end  = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Slave never answered: terminate with an error, no data.
          rdata_d   = '0;
          err_d     = 1'b1;
          done_d    = onehot2(owner_q);
          psel_d    = 1'b0;
          penable_d = 1'b0;
          xfer_end  = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything, aborting any transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pstrb_o   = pstrb_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: directed transfers push expected
// grants/completions; a negedge monitor pops and compares whenever the DUT
// pulses gnt_o or done_o. A small slave model answers with a programmable
// number of wait cycles.
module tb_apb_master_arbiter;

  localparam int BW = 16;
  localparam int AW = 16;
  localparam int SW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [1:0]    req_i = '0;
  logic [1:0]    wr_i = '0;
  logic [AW-1:0] addr0_i = '0, addr1_i = '0;
  logic [BW-1:0] wdata0_i = '0, wdata1_i = '0;
  logic [SW-1:0] strb0_i = '0, strb1_i = '0;
  logic [1:0]    gnt_o, done_o;
  logic [BW-1:0] rdata_o;
  logic          err_o, psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [BW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic [BW-1:0] prdata_i = '0;
  logic          pready_i = 1'b0;
  logic          pslverr_i = 1'b0;

  apb_master_arbiter #(
    .BUS_WIDTH (BW),
    .ADDR_WIDTH(AW),
    .MAX_DIM   (SW),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .wr_i      (wr_i),
    .addr0_i   (addr0_i),
    .addr1_i   (addr1_i),
    .wdata0_i  (wdata0_i),
    .wdata1_i  (wdata1_i),
    .strb0_i   (strb0_i),
    .strb1_i   (strb1_i),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .paddr_o   (paddr_o),
    .pwdata_o  (pwdata_o),
    .pstrb_o   (pstrb_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    gnt;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
    logic [SW-1:0] strb;
  } gexp_t;

  typedef struct {
    logic [1:0]    done;
    logic [BW-1:0] rdata;
    logic          err;
    int            len;
    logic [AW-1:0] addr;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave model: pready after slv_wait low ACCESS cycles.
  int            slv_wait = 0;
  logic [BW-1:0] slv_rdata = '0;
  logic          slv_err = 1'b0;
  logic          slv_err_wait = 1'b0;
  int            acc_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (psel_o && penable_o) begin
      if (acc_cnt == slv_wait) begin
        pready_i  = 1'b1;
        pslverr_i = slv_err;
        prdata_i  = slv_rdata;
      end else begin
        pready_i  = 1'b0;
        pslverr_i = slv_err_wait;
        prdata_i  = 16'hDEAD;
      end
      acc_cnt++;
    end else begin
      acc_cnt   = 0;
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      prdata_i  = 16'hDEAD;
    end
  end

  // Monitor: compare every grant and completion pulse against the queues.
  int run_len = 0;
  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      run_len = 0;
    end else begin
      if (penable_o) run_len++;
      if (gnt_o != 2'b00) begin
        if (gq.size() == 0) begin
          check("unexpected_gnt", gnt_o, 2'b00);
        end else begin
          gexp_t g;
          g = gq.pop_front();
          check("gnt", gnt_o, g.gnt);
          check("gnt_psel_penable", {psel_o, penable_o}, 2'b10);
          check("pwrite", pwrite_o, g.wr);
          check("paddr", paddr_o, g.addr);
          check("pstrb", pstrb_o, g.strb);
          if (g.wr) check("pwdata", pwdata_o, g.wdata);
        end
      end
      if (done_o != 2'b00) begin
        if (dq.size() == 0) begin
          check("unexpected_done", done_o, 2'b00);
        end else begin
          dexp_t d;
          d = dq.pop_front();
          check("done", done_o, d.done);
          check("rdata", rdata_o, d.rdata);
          check("err", err_o, d.err);
          check("access_len", run_len, d.len);
          check("done_psel", {psel_o, penable_o}, 2'b00);
          check("paddr_held", paddr_o, d.addr);
        end
        run_len = 0;
      end
    end
  end

  task automatic wait_gnt(input int k);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (gnt_o[k]) return;
    end
    check("gnt_wait_expired", 0, 1);
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done_o[k]) return;
    end
    check("done_wait_expired", 0, 1);
  endtask

  // One transfer from a single requester with hand-computed expectations.
  task automatic xfer(input int k, input logic wr, input logic [AW-1:0] addr,
                      input logic [BW-1:0] wdata, input logic [SW-1:0] strb,
                      input int wt, input logic [BW-1:0] prd, input logic serr,
                      input logic serrw, input logic [SW-1:0] exp_strb,
                      input logic [BW-1:0] exp_rd, input logic exp_err,
                      input int exp_len);
    int t0, tg, td;
    slv_wait = wt; slv_rdata = prd; slv_err = serr; slv_err_wait = serrw;
    if (k == 0) begin
      wr_i[0] = wr; addr0_i = addr; wdata0_i = wdata; strb0_i = strb;
    end else begin
      wr_i[1] = wr; addr1_i = addr; wdata1_i = wdata; strb1_i = strb;
    end
    gq.push_back('{gnt: (k == 0) ? 2'b01 : 2'b10, wr: wr, addr: addr, wdata: wdata, strb: exp_strb});
    dq.push_back('{done: (k == 0) ? 2'b01 : 2'b10, rdata: exp_rd, err: exp_err, len: exp_len, addr: addr});
    t0 = cyc;
    req_i[k] = 1'b1;
    wait_gnt(k);
    tg = cyc;
    req_i[k] = 1'b0;
    // Fields changing after the grant edge must not reach the bus.
    if (k == 0) begin addr0_i = '1; wdata0_i = '1; strb0_i = '0; end
    else        begin addr1_i = '1; wdata1_i = '1; strb1_i = '0; end
    wait_done(k);
    td = cyc;
    check("lat_gnt", tg - t0, 1);
    check("lat_done", td - tg, 1 + exp_len);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    int tprev;
    repeat (2) @(posedge clk);
    #1;
    check("rst_psel", psel_o, 0);
    check("rst_penable", penable_o, 0);
    check("rst_gnt", gnt_o, 0);
    check("rst_done", done_o, 0);
    check("rst_paddr", paddr_o, 0);
    check("rst_pwdata", pwdata_o, 0);
    check("rst_pstrb", pstrb_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_err", err_o, 0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // Zero-wait write from requester 0.
    xfer(0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 0, 16'h5555, 1'b0, 1'b0,
         2'b11, 16'h0000, 1'b0, 1);
    // Read from requester 1 with three wait states.
    xfer(1, 1'b0, 16'h0020, 16'h7777, 2'b11, 3, 16'h1234, 1'b0, 1'b0,
         2'b00, 16'h1234, 1'b0, 4);

    // Both requesting continuously: 0,1,0,1 at three-cycle spacing.
    wr_i = 2'b01;
    addr0_i = 16'h0100; wdata0_i = 16'h1111; strb0_i = 2'b01;
    addr1_i = 16'h0200; wdata1_i = 16'h2222; strb1_i = 2'b10;
    slv_wait = 0; slv_rdata = 16'hA5A5; slv_err = 1'b0; slv_err_wait = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gq.push_back('{gnt: 2'b01, wr: 1'b1, addr: 16'h0100, wdata: 16'h1111, strb: 2'b01});
      gq.push_back('{gnt: 2'b10, wr: 1'b0, addr: 16'h0200, wdata: 16'h2222, strb: 2'b00});
      dq.push_back('{done: 2'b01, rdata: 16'h0000, err: 1'b0, len: 1, addr: 16'h0100});
      dq.push_back('{done: 2'b10, rdata: 16'hA5A5, err: 1'b0, len: 1, addr: 16'h0200});
    end
    req_i = 2'b11;
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 20; j++) begin
        @(posedge clk); #1;
        if (gnt_o != 2'b00) break;
      end
      if (gnt_o == 2'b00) check("rr_gnt_wait_expired", 0, 1);
      if (i > 0) check("rr_spacing", cyc - tprev, 3);
      tprev = cyc;
    end
    req_i = 2'b00;
    wait_done(1);

    // Stuck slave: watchdog ends ACCESS after exactly TO cycles.
    xfer(0, 1'b1, 16'h0030, 16'hCAFE, 2'b11, 1000, 16'h0BAD, 1'b0, 1'b0,
         2'b11, 16'h0000, 1'b1, 16);
    // Following request proceeds normally.
    xfer(1, 1'b1, 16'h0040, 16'h0F0F, 2'b01, 0, 16'h0BAD, 1'b0, 1'b0,
         2'b01, 16'h0000, 1'b0, 1);
    // pready on the last watchdog cycle wins over the timeout.
    xfer(0, 1'b0, 16'h0050, 16'h0000, 2'b11, 15, 16'h4321, 1'b0, 1'b0,
         2'b00, 16'h4321, 1'b0, 16);
    // Slave error on completion; pslverr during wait states also high.
    xfer(0, 1'b1, 16'h0060, 16'h00FF, 2'b10, 2, 16'h0BAD, 1'b1, 1'b1,
         2'b10, 16'h0000, 1'b1, 3);
    // pslverr only during wait states: ignored.
    xfer(0, 1'b1, 16'h0070, 16'hFF00, 2'b11, 2, 16'h0BAD, 1'b0, 1'b1,
         2'b11, 16'h0000, 1'b0, 3);

    // Reset during ACCESS of requester 1 (pointer currently favours 1).
    slv_wait = 1000; slv_err_wait = 1'b0;
    wr_i[1] = 1'b0; addr1_i = 16'h0080; wdata1_i = 16'h0000; strb1_i = 2'b11;
    gq.push_back('{gnt: 2'b10, wr: 1'b0, addr: 16'h0080, wdata: 16'h0000, strb: 2'b00});
    req_i[1] = 1'b1;
    wait_gnt(1);
    req_i[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_penable", penable_o, 1);
    #1;
    rst_i = 1'b1;
    #1;
    check("async_rst_psel", psel_o, 0);
    check("async_rst_penable", penable_o, 0);
    check("async_rst_done", done_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;

    // After release, a tie goes to requester 0.
    wr_i = 2'b01;
    addr0_i = 16'h0090; wdata0_i = 16'h9999; strb0_i = 2'b11;
    addr1_i = 16'h00A0; wdata1_i = 16'h0000; strb1_i = 2'b11;
    slv_wait = 0; slv_rdata = 16'h0BAD; slv_err = 1'b0;
    gq.push_back('{gnt: 2'b01, wr: 1'b1, addr: 16'h0090, wdata: 16'h9999, strb: 2'b11});
    gq.push_back('{gnt: 2'b10, wr: 1'b0, addr: 16'h00A0, wdata: 16'h0000, strb: 2'b00});
    dq.push_back('{done: 2'b01, rdata: 16'h0000, err: 1'b0, len: 1, addr: 16'h0090});
    dq.push_back('{done: 2'b10, rdata: 16'h0BAD, err: 1'b0, len: 1, addr: 16'h00A0});
    req_i = 2'b11;
    wait_gnt(0);
    req_i[0] = 1'b0;
    wait_gnt(1);
    req_i[1] = 1'b0;
    wait_done(1);

    repeat (4) @(posedge clk);
    #1;
    check("gnt_queue_drained", gq.size(), 0);
    check("done_queue_drained", dq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Two-port APB master that shares the single APB slave port of the matmul accelerator between two requesters, e.g. a host configuration path and a DMA/sequencer path. It arbitrates round-robin, drives the full APB setup/access protocol toward the slave, waits for `pready`, and returns read data and error status to the winning requester. A watchdog terminates any access the slave never completes.

## Interface
Parameters:
- `BUS_WIDTH`, 16: APB data width; must be a multiple of 8.
- `ADDR_WIDTH`, 16: APB address width.
- `MAX_DIM`, `BUS_WIDTH/8`: strobe width, one bit per byte.
- `TIMEOUT`, 16: maximum ACCESS cycles before forced error termination; must be ≥ 2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `req_i` in 2: per-requester transfer request, level.
- `wr_i` in 2: per-requester direction; 1 = write.
- `addr0_i`, `addr1_i` in ADDR_WIDTH each: requester address.
- `wdata0_i`, `wdata1_i` in BUS_WIDTH each: requester write data.
- `strb0_i`, `strb1_i` in MAX_DIM each: requester write strobes.
- `gnt_o` out 2: one-hot, 1-cycle grant pulse.
- `done_o` out 2: one-hot, 1-cycle completion pulse.
- `rdata_o` out BUS_WIDTH: read data; valid while `done_o` is nonzero.
- `err_o` out 1: transfer error; valid while `done_o` is nonzero.
- `psel_o`, `penable_o`, `pwrite_o` out 1 each: APB controls.
- `paddr_o` out ADDR_WIDTH, `pwdata_o` out BUS_WIDTH, `pstrb_o` out MAX_DIM: APB request fields.
- `prdata_i` in BUS_WIDTH, `pready_i` in 1, `pslverr_i` in 1: APB slave response.

## Operation
- FSM has three states: IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10. Unused encoding 2'b11 returns to IDLE.
- IDLE:
  - If `req_i` is nonzero, select a winner round-robin: the requester not served last wins a tie.
  - After reset, requester 0 has priority.
  - On that edge, latch the winner's `wr`/`addr`/`wdata`/`strb` into `pwrite_o`/`paddr_o`/`pwdata_o`/`pstrb_o` (`pstrb_o` forced to 0 for reads).
  - Set `gnt_o[winner]`, go to SETUP.
- SETUP: `psel_o=1`, `penable_o=0`. Unconditionally go to ACCESS and clear the watchdog counter.
- ACCESS:
  - `psel_o=1`, `penable_o=1`; the watchdog counter increments each cycle.
  - If `pready_i`: latch `rdata_o = prdata_i` for reads or 0 for writes, `err_o = pslverr_i`, pulse `done_o[winner]`, go to IDLE, and update the round-robin pointer.
  - Else if the counter equals `TIMEOUT-1`: complete with `rdata_o=0`, `err_o=1`, go to IDLE.
  - `pready_i` wins over the timeout when both occur in the same cycle.
- Requesters must deassert `req_i` in the cycle `gnt_o` is high. A request still high in IDLE after `done_o` is treated as a new transfer.
- Request fields sampled outside the grant edge are ignored; APB fields are stable from SETUP through the end of ACCESS.
- `pslverr_i` and `prdata_i` are ignored except on the completing edge.

## Timing
- Reset (asynchronous, immediate): state IDLE, RR pointer favors requester 0, counter 0, all outputs 0, including `paddr_o`/`pwdata_o`/`pstrb_o`/`rdata_o`/`err_o`.
- Reset mid-transfer aborts the transfer: no `done_o` pulse, and `psel_o` drops immediately.
- Zero-wait transfer timeline:
  - Cycle 0: `req` sampled in IDLE.
  - Cycle 1: SETUP, `gnt_o` high.
  - Cycle 2: ACCESS with `pready_i=1`.
  - Cycle 3: `done_o`/`rdata_o`/`err_o` valid, state IDLE.
- Back-to-back throughput: the next grant is sampled in cycle 3 and its SETUP is in cycle 4, so 3 cycles per transfer with zero wait.
- Each `pready_i`-low ACCESS cycle adds one cycle of latency.
- Timeout: with `pready_i` stuck low, ACCESS lasts exactly TIMEOUT cycles, then `done_o` with `err_o=1`.
- `psel_o`/`penable_o` are registered from state, so there are no combinational paths from inputs to outputs.

## Structure
- Shared package `apb_pkg`: state encodings (IDLE/SETUP/ACCESS) and a `BYTE_W=8` constant.
- Sub-module `rr_arbiter_2`: a combinational 2-way round-robin pick plus a registered last-grant pointer, updated only on transfer completion.
- Watchdog counter width is `$clog2(TIMEOUT)`.

## Test plan
- Write, requester 0: `addr0=16'h0010`, `wdata0=16'hBEEF`, `strb0=2'b11`, `pready_i` tied high → `psel_o` in cycles 1–2, `penable_o` in cycle 2, `paddr_o=0010`, `pwdata_o=BEEF`, `pstrb_o=11`, `done_o=01` in cycle 3, `err_o=0`.
- Read, requester 1: `addr1=16'h0020`, slave returns `prdata_i=16'h1234` after 3 wait cycles → ACCESS lasts 4 cycles, `done_o=10`, `rdata_o=1234`, `pstrb_o=00`.
- Both `req_i=2'b11` held continuously, zero wait → grants alternate 0,1,0,1 on a 3-cycle cadence, with no `gnt_o` overlap.
- `pready_i` stuck low with `TIMEOUT=16` → exactly 16 ACCESS cycles, then `done_o` with `err_o=1` and `rdata_o=0`; next request proceeds normally.
- Slave error: `pslverr_i=1` with `pready_i=1` on a write → `err_o=1` with `done_o`; `pslverr_i=1` while `pready_i=0` → no effect on `err_o`.
- `rst_i` asserted during ACCESS → `psel_o`/`penable_o` drop without waiting for a clock edge, no `done_o` pulse, and the first request after release goes to requester 0.
